// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline register stage.
package pipe_pkg;

    // Stage occupancy states: no entry, main only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int OCC_W = 2;

    // Number of stored entries implied by a state.
    function automatic logic [OCC_W-1:0] occ_of_state(input skid_state_t s);
        logic [OCC_W-1:0] occ;
        occ = '0;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with async reset and a synchronous clear that overrides load.
// The register only changes on load or clear, so idle cycles do not toggle it.
module pipe_data_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Payload storage: reset and clear both return to RESET_VAL; clear wins over load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (clear) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with a two-entry skid buffer and synchronous flush.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high on the same side (push = in_valid & in_ready, pop = out_valid &
// out_ready). valid must not depend on ready; in_ready comes straight from a
// flop, so there is no combinational path from out_ready back to in_ready.
// The skid entry absorbs the one word that arrives while in_ready is still
// high in the cycle downstream first stalls.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy,
    output skid_state_t      dbg_state
);

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic             in_ready_q;
    logic             push;
    logic             pop;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;
    logic             data_clear;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign push       = in_valid & in_ready_q;
    assign pop        = out_valid & out_ready;
    assign data_clear = flush & CLEAR_ON_FLUSH;

    // State register plus the registered ready, which is high unless the next state is FULL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Next-state and load steering; flush overrides push and pop and loads nothing.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (push && pop) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end else if (!push && pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move the state.
                    if (pop) begin
                        state_d        = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Main entry takes the skid word when draining FULL, otherwise the upstream word.
    always_comb begin
        main_d = main_from_skid ? skid_q : in_data;
    end

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (data_clear),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (data_clear),
        .d     (in_data),
        .q     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_of_state(state_q);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed steps plus random traffic against a queue model.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    localparam int               W       = 16;
    localparam logic [W-1:0]     RESET_A = 16'h00F0;
    localparam logic [W-1:0]     RESET_B = 16'h0F0F;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: CLEAR_ON_FLUSH = 1 ----------------
    logic             flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [W-1:0]     in_data_a, out_data_a;
    logic [OCC_W-1:0] occ_a;
    skid_state_t      st_a;

    pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RESET_A), .CLEAR_ON_FLUSH(1'b1)) dut_a (
        .clk       (clk),
        .reset     (rst_n),
        .flush     (flush_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_data   (in_data_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_data  (out_data_a),
        .occupancy (occ_a),
        .dbg_state (st_a)
    );

    // ---------------- DUT B: CLEAR_ON_FLUSH = 0 ----------------
    logic             flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [W-1:0]     in_data_b, out_data_b;
    logic [OCC_W-1:0] occ_b;
    skid_state_t      st_b;

    pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RESET_B), .CLEAR_ON_FLUSH(1'b0)) dut_b (
        .clk       (clk),
        .reset     (rst_n),
        .flush     (flush_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b),
        .occupancy (occ_b),
        .dbg_state (st_b)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_main;
    int           n_vec;
    int           n_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of DUT A: compare against the model at the falling edge,
    // then advance the model with the handshakes seen at the rising edge.
    task automatic cycle_a();
        bit push;
        bit pop;
        @(negedge clk);
        check("a_out_valid", {31'd0, out_valid_a}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
        check("a_occupancy", {30'd0, occ_a}, exp_q.size());
        check("a_in_ready", {31'd0, in_ready_a}, (exp_q.size() < 2) ? 32'd1 : 32'd0);
        check("a_out_data", {16'd0, out_data_a}, {16'd0, model_main});
        check("a_skid_without_main", {31'd0, (occ_a == 2'd2) && !out_valid_a}, 32'd0);
        push = in_valid_a && (exp_q.size() < 2);
        pop  = (exp_q.size() != 0) && out_ready_a;
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (flush_a) begin
            exp_q.delete();
            model_main = RESET_A;
        end else if (push) begin
            exp_q.push_back(in_data_a);
        end
        if (exp_q.size() != 0) model_main = exp_q[0];
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        in_valid_a  = v;
        in_data_a   = d;
        out_ready_a = r;
        flush_a     = f;
    endtask

    task automatic step_b();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec      = 0;
        n_mis      = 0;
        model_main = RESET_A;
        rst_n      = 1'b0;
        drive_a(1'b0, '0, 1'b0, 1'b0);
        flush_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("rst_occupancy", {30'd0, occ_a}, 32'd0);
        check("rst_out_data", {16'd0, out_data_a}, {16'd0, RESET_A});
        check("rst_b_out_data", {16'd0, out_data_b}, {16'd0, RESET_B});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming 1..8 with ready always high
        for (int i = 1; i <= 8; i++) begin
            drive_a(1'b1, W'(i), 1'b1, 1'b0);
            cycle_a();
        end
        drive_a(1'b0, '0, 1'b1, 1'b0);
        cycle_a();
        cycle_a();

        // Stall into skid, then drain
        drive_a(1'b1, 16'h000A, 1'b0, 1'b0); cycle_a();
        drive_a(1'b1, 16'h000B, 1'b0, 1'b0); cycle_a();
        drive_a(1'b1, 16'h00EE, 1'b0, 1'b0); cycle_a();  // refused: in_ready is low
        drive_a(1'b0, '0, 1'b1, 1'b0);       cycle_a();
        cycle_a();
        cycle_a();

        // Flush while FULL with a same-cycle push of 0xC
        drive_a(1'b1, 16'h0011, 1'b0, 1'b0); cycle_a();
        drive_a(1'b1, 16'h0022, 1'b0, 1'b0); cycle_a();
        drive_a(1'b1, 16'h000C, 1'b1, 1'b1); cycle_a();
        drive_a(1'b0, '0, 1'b1, 1'b0);       cycle_a();
        cycle_a();

        // CLEAR_ON_FLUSH = 0 on DUT B; DUT A idles meanwhile
        drive_a(1'b0, '0, 1'b0, 1'b0);
        in_valid_b = 1'b1; in_data_b = 16'h0055; step_b();
        in_valid_b = 1'b0;
        check("b_load_valid", {31'd0, out_valid_b}, 32'd1);
        check("b_load_data", {16'd0, out_data_b}, 32'h0055);
        flush_b = 1'b1; step_b();
        flush_b = 1'b0;
        check("b_flush_valid", {31'd0, out_valid_b}, 32'd0);
        check("b_flush_occ", {30'd0, occ_b}, 32'd0);
        check("b_flush_ready", {31'd0, in_ready_b}, 32'd1);
        check("b_flush_data_held", {16'd0, out_data_b}, 32'h0055);
        in_valid_b = 1'b1; in_data_b = 16'h0066; step_b();
        in_valid_b = 1'b0; out_ready_b = 1'b1;
        check("b_next_valid", {31'd0, out_valid_b}, 32'd1);
        check("b_next_data", {16'd0, out_data_b}, 32'h0066);
        step_b();
        check("b_drained", {31'd0, out_valid_b}, 32'd0);
        out_ready_b = 1'b0;

        // Async reset between edges while FULL
        drive_a(1'b1, 16'h0033, 1'b0, 1'b0); cycle_a();
        drive_a(1'b1, 16'h0044, 1'b0, 1'b0); cycle_a();
        drive_a(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("arst_occupancy", {30'd0, occ_a}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("arst_out_data", {16'd0, out_data_a}, {16'd0, RESET_A});
        exp_q.delete();
        model_main = RESET_A;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_a(1'b1, 16'h0001, 1'b0, 1'b0); cycle_a();
        drive_a(1'b0, '0, 1'b1, 1'b0);       cycle_a();
        cycle_a();

        // Random valid/ready with occasional flush
        for (int i = 0; i < 10000; i++) begin
            drive_a(1'($urandom_range(0, 1)), W'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 5));
            cycle_a();
        end
        drive_a(1'b0, '0, 1'b1, 1'b0);
        cycle_a();
        cycle_a();
        cycle_a();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline register stage with a valid/ready handshake, a two-entry skid buffer, and a synchronous flush.
- Sits between core pipeline stages (e.g. IF/ID, ID/EX) and replaces bare enable-less flops.
- Back-pressure can stall upstream without a combinational ready path.
- A redirect or flush kills in-flight contents in one cycle.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VAL, '0 (WIDTH bits), payload value after reset; also after flush when CLEAR_ON_FLUSH=1.
- CLEAR_ON_FLUSH, 1, 1: flush also forces stored payloads to RESET_VAL; 0: flush clears only the valid bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all stored entries; active-high.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload of the oldest entry.
- occupancy  output  2  number of stored entries, 0..2.

Behaviour:
- Storage: main entry (drives outputs) and skid entry. Each entry is a data register plus a valid bit.
- States: EMPTY (no entries), ONE (main valid), FULL (main and skid valid).
- Handshake definitions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Outputs:
  - out_valid = main valid.
  - out_data = main data.
  - in_ready = !(next state == FULL), registered; equivalently in_ready=0 iff skid is valid.
  - occupancy = number of valid entries.
- Transitions at posedge clk when flush=0:
  - EMPTY, push -> ONE; main <= in_data. Latency in->out is 1 cycle.
  - ONE, push & !pop -> FULL; skid <= in_data.
  - ONE, push & pop -> ONE; main <= in_data.
  - ONE, !push & pop -> EMPTY.
  - FULL, pop -> ONE; main <= skid. in_ready is 0 in FULL, so no push can occur.
  - Any other combination: hold.
- Ordering: strictly FIFO; no payload is duplicated or dropped.
- Flush (sync), priority over push and pop in the same cycle:
  - All valid bits are cleared and the state becomes EMPTY; in_ready=1 on the next cycle.
  - A same-cycle push is discarded.
  - A same-cycle pop still counts as a completed transfer for downstream.
  - CLEAR_ON_FLUSH=1: both data registers <= RESET_VAL. CLEAR_ON_FLUSH=0: data registers hold.
- Reset (async, active-low), asserted at any time including mid-transfer:
  - State EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - Both data registers = RESET_VAL.
  - Takes effect immediately without a clock edge.
- Data registers do not toggle on cycles with no load (power); this is not observable functionally.
- in_data is sampled only on push; its value is don't-care otherwise.
- The design must never reach a state where skid is valid and main is invalid; the bench asserts this.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {EMPTY, ONE, FULL}.
  - localparam OCC_W = 2.
- One sub-module: pipe_data_reg #(WIDTH, RESET_VAL).
  - Ports: clk, reset, load, clear, d, q.
  - Async active-low reset to RESET_VAL; sync clear to RESET_VAL with priority over load.
  - Instantiated twice (main, skid).
- Top holds the state register and the handshake logic.

Test Plan:
- Streaming: in_valid=1, out_ready=1 constantly, in_data=1,2,3,... -> out_data=1,2,3,... each one cycle later; occupancy stays 1; in_ready stays 1.
- Stall into skid: push 0xA, then push 0xB with out_ready=0 -> occupancy=2, in_ready=0. Then out_ready=1 -> out_data 0xA, then 0xB; in_ready returns to 1 the cycle after the first pop.
- Flush while FULL with same-cycle in_valid=1, in_data=0xC (CLEAR_ON_FLUSH=1) -> next cycle out_valid=0, occupancy=0, in_ready=1, out_data=RESET_VAL; 0xC never appears at the output.
- Flush with CLEAR_ON_FLUSH=0, holding 0x55 -> out_valid=0 and out_data stays 0x55; a subsequent push of 0x66 is output normally.
- Async reset asserted between clock edges while FULL -> outputs are immediately out_valid=0, occupancy=0, in_ready=1, out_data=RESET_VAL. After reset release, the first push of 0x1 appears one cycle later.
- Random valid/ready (10k cycles, 5% flush) against a reference queue model -> no loss, duplication or reordering outside flushes; the skid-without-main assertion never fires.
